// File: rtl/fir_front_end_pkg.sv
// Shared definitions for the FIR front end: controller state encoding and a clog2 helper.
package fir_front_end_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_SWAP  = 2'd2
   } fe_state_e;

   function automatic int fe_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fir_front_end_sync_fifo.sv
// Single-clock sample FIFO with pointer/count bookkeeping.
// Push is ignored when full and pop is ignored when empty.
module fir_sync_fifo
   import fir_front_end_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] iv_wdata,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] ov_rdata,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int PW = fe_clog2(FIFO_DEPTH);

   logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign push_ok  = i_push && !o_full;
   assign pop_ok   = i_pop && !o_empty;
   assign o_full   = (count_q == (PW+1)'(FIFO_DEPTH));
   assign o_empty  = (count_q == '0);
   assign ov_rdata = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= iv_wdata;
   end

endmodule

// File: rtl/fir_front_end.sv
// Feeder for the FIR tap chain: sample FIFO, tap-enable/data output, shadow/active coefficients.
// Define FIR_FRONT_END_FLUSH_EN to zero the tap history with NUM_TAPS pulses before each swap.
module fir_front_end
   import fir_front_end_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_TAPS   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_s_valid,
   input  logic [DATA_WIDTH-1:0]          iv_s_data,
   output logic                           o_s_ready,
   input  logic                           i_coef_wr,
   input  logic [$clog2(NUM_TAPS)-1:0]    iv_coef_addr,
   input  logic [DATA_WIDTH-1:0]          iv_coef_data,
   input  logic                           i_coef_commit,
   output logic                           o_tap_en,
   output logic [DATA_WIDTH-1:0]          ov_tap_din,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
   output logic                           o_busy
);

   fe_state_e                    state_q;
   logic                         tap_en_q;
   logic signed [DATA_WIDTH-1:0] tap_din_q;
   logic signed [DATA_WIDTH-1:0] shadow_q [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] active_q [NUM_TAPS];
   logic                         fifo_full, fifo_empty, fifo_pop;
   logic [DATA_WIDTH-1:0]        fifo_rdata;

`ifdef FIR_FRONT_END_FLUSH_EN
   localparam int CW = (fe_clog2(NUM_TAPS) < 1) ? 1 : fe_clog2(NUM_TAPS);
   logic [CW-1:0] flush_cnt_q;
`endif

   fir_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_push   (i_s_valid),
      .iv_wdata (iv_s_data),
      .i_pop    (fifo_pop),
      .ov_rdata (fifo_rdata),
      .o_full   (fifo_full),
      .o_empty  (fifo_empty)
   );

   assign o_s_ready  = !fifo_full;
   assign fifo_pop   = (state_q == ST_RUN) && !fifo_empty;
   assign o_tap_en   = tap_en_q;
   assign ov_tap_din = tap_din_q;
   assign o_busy     = (state_q != ST_RUN);

   // Controller: commits are only honoured in RUN, so a commit while busy is dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_RUN;
         tap_en_q  <= 1'b0;
         tap_din_q <= '0;
`ifdef FIR_FRONT_END_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else begin
         tap_en_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (fifo_pop) begin
                  tap_en_q  <= 1'b1;
                  tap_din_q <= fifo_rdata;
               end
               if (i_coef_commit) begin
`ifdef FIR_FRONT_END_FLUSH_EN
                  state_q     <= ST_FLUSH;
                  flush_cnt_q <= CW'(NUM_TAPS - 1);
`else
                  state_q <= ST_SWAP;
`endif
               end
            end
`ifdef FIR_FRONT_END_FLUSH_EN
            ST_FLUSH: begin
               tap_en_q  <= 1'b1;
               tap_din_q <= '0;
               if (flush_cnt_q == '0) state_q <= ST_SWAP;
               else                   flush_cnt_q <= flush_cnt_q - 1'b1;
            end
`endif
            ST_SWAP: state_q <= ST_RUN;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // A write landing in the SWAP cycle reaches shadow only; active copies the old shadow.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
      end else begin
         if (i_coef_wr && (32'(iv_coef_addr) < NUM_TAPS))
            shadow_q[iv_coef_addr] <= iv_coef_data;
         if (state_q == ST_SWAP) begin
            for (int k = 0; k < NUM_TAPS; k++) active_q[k] <= shadow_q[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
      assign ov_weights[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
   end

endmodule

// File: tb/tb_fir_front_end.sv
// Directed bench for fir_front_end; expected values are hand-computed constants.
module tb_fir_front_end;

   localparam int DW = 8;
   localparam int NT = 8;
   localparam int FD = 4;
`ifdef FIR_FRONT_END_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif
   localparam int BUSY_CYC = FLUSH_EN ? NT + 1 : 1;
   localparam int ZEROS    = FLUSH_EN ? NT : 0;

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          coef_wr;
   logic [2:0]    coef_addr;
   logic [DW-1:0] coef_data;
   logic          coef_commit;
   logic          tap_en;
   logic [DW-1:0] tap_din;
   logic [NT*DW-1:0] weights;
   logic          busy;

   fir_front_end #(
      .DATA_WIDTH (DW),
      .NUM_TAPS   (NT),
      .FIFO_DEPTH (FD)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_s_valid     (s_valid),
      .iv_s_data     (s_data),
      .o_s_ready     (s_ready),
      .i_coef_wr     (coef_wr),
      .iv_coef_addr  (coef_addr),
      .iv_coef_data  (coef_data),
      .i_coef_commit (coef_commit),
      .o_tap_en      (tap_en),
      .ov_tap_din    (tap_din),
      .ov_weights    (weights),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] pulses[$];
   bit            log_en = 1'b0;
   int            busy_cnt = 0;

   always @(negedge clk) begin
      if (log_en) begin
         if (tap_en) pulses.push_back(tap_din);
         if (busy) busy_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] vec [4];
   logic [DW-1:0] exp_d;
   bit            acc;
   bit            ready_after4;

   initial begin
      vec = '{8'h05, 8'hFD, 8'h7F, 8'h80};
      rst = 1'b1; s_valid = 1'b0; s_data = '0; coef_wr = 1'b0; coef_addr = '0;
      coef_data = '0; coef_commit = 1'b0; ready_after4 = 1'b1;
      tick; tick;
      rst = 1'b0;
      tick;

      chk("rst_weights", 64'(weights), 64'h0);
      chk("rst_tap_en",  64'(tap_en),  64'h0);
      chk("rst_ready",   64'(s_ready), 64'h1);
      chk("rst_busy",    64'(busy),    64'h0);
      chk("rst_din",     64'(tap_din), 64'h0);

      // Stream four samples back-to-back; pulses expected two cycles after acceptance.
      for (int i = 0; i < 6; i++) begin
         s_valid = (i < 4);
         if (i < 4) s_data = vec[i];
         tick;
         if (i == 0 || i == 5) begin
            chk("stream_gap", 64'(tap_en), 64'h0);
         end else begin
            chk("stream_en",  64'(tap_en),  64'h1);
            chk("stream_din", 64'(tap_din), 64'(vec[i-1]));
         end
      end
      chk("stream_hold_din", 64'(tap_din), 64'h80);
      s_valid = 1'b0;

      for (int k = 0; k < NT; k++) begin
         coef_wr = 1'b1; coef_addr = 3'(k); coef_data = 8'(k + 1);
         tick;
      end
      coef_wr = 1'b0;
      chk("shadow_not_active", 64'(weights), 64'h0);

      // Commit, then push five samples while the sink is stalled.
      pulses.delete(); busy_cnt = 0; log_en = 1'b1;
      coef_commit = 1'b1;
      tick;
      coef_commit = 1'b0;
      for (int s = 0; s < 5; s++) begin
         s_valid = 1'b1;
         s_data  = 8'(16 + s);
         if (s == 4) ready_after4 = s_ready;
         acc = 1'b0;
         for (int w = 0; w < 40 && !acc; w++) begin
            acc = s_ready;
            tick;
         end
         chk("fill_accept", 64'(acc), 64'h1);
      end
      s_valid = 1'b0;
`ifdef FIR_FRONT_END_FLUSH_EN
      chk("fill_full_ready", 64'(ready_after4), 64'h0);
`endif
      repeat (20) tick;
      log_en = 1'b0;
      chk("commit_busy_cycles", 64'(busy_cnt), 64'(BUSY_CYC));
      chk("commit_pulse_count", 64'(pulses.size()), 64'(ZEROS + 5));
      for (int i = 0; i < ZEROS + 5; i++) begin
         exp_d = (i < ZEROS) ? 8'h00 : 8'(16 + i - ZEROS);
         if (i < pulses.size()) chk("commit_pulse_data", 64'(pulses[i]), 64'(exp_d));
      end
      chk("commit_weights", 64'(weights), 64'h0807060504030201);

      // Second commit while busy is dropped; a write in the SWAP cycle stays in shadow.
      coef_wr = 1'b1; coef_addr = 3'd1; coef_data = 8'hFE;
      tick;
      coef_wr = 1'b0;
      busy_cnt = 0; log_en = 1'b1;
      coef_commit = 1'b1;
      tick;
      for (int c = 1; c <= BUSY_CYC; c++) begin
         coef_commit = (c == 1);
         coef_wr     = (c == BUSY_CYC);
         coef_addr   = 3'd0;
         coef_data   = 8'h55;
         chk("busy_during_swap", 64'(busy), 64'h1);
         tick;
      end
      coef_commit = 1'b0; coef_wr = 1'b0;
      chk("busy_after_swap", 64'(busy), 64'h0);
      repeat (15) tick;
      log_en = 1'b0;
      chk("ignored_commit_busy", 64'(busy_cnt), 64'(BUSY_CYC));
      chk("swap_write_shadow_only", 64'(weights), 64'h080706050403FE01);

      coef_commit = 1'b1;
      tick;
      coef_commit = 1'b0;
      repeat (BUSY_CYC + 3) tick;
      chk("next_commit_weights", 64'(weights), 64'h080706050403FE55);

      // Reset in the cycle after a commit (FLUSH or SWAP) with a queued sample.
      coef_commit = 1'b1; s_valid = 1'b1; s_data = 8'h22;
      tick;
      coef_commit = 1'b0; s_valid = 1'b0;
      chk("busy_before_rst", 64'(busy), 64'h1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_busy",    64'(busy),    64'h0);
      chk("midrst_weights", 64'(weights), 64'h0);
      chk("midrst_tap_en",  64'(tap_en),  64'h0);
      chk("midrst_ready",   64'(s_ready), 64'h1);
      chk("midrst_din",     64'(tap_din), 64'h0);
      pulses.delete(); log_en = 1'b1;
      repeat (6) tick;
      log_en = 1'b0;
      chk("midrst_fifo_empty", 64'(pulses.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
